// File: rtl/regfile_wb_arbiter_if.sv
// Signal bundle shared by the two writeback requesters, the issue-side
// scoreboard hook and the registered regfile write port.
interface regfile_wb_arbiter_if;
    logic        i_r0_valid;
    logic [4:0]  i_r0_addr;
    logic [31:0] i_r0_data;
    logic        o_r0_ready;

    logic        i_r1_valid;
    logic [4:0]  i_r1_addr;
    logic [31:0] i_r1_data;
    logic        o_r1_ready;

    logic        i_issue_valid;
    logic [4:0]  i_issue_addr;

    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [31:0] o_pending;

    // The requester/issue side drives requests and observes grants and the write port.
    modport master (
        output i_r0_valid, i_r0_addr, i_r0_data,
        output i_r1_valid, i_r1_addr, i_r1_data,
        output i_issue_valid, i_issue_addr,
        input  o_r0_ready, o_r1_ready,
        input  o_rd_wren, o_rd_addr, o_rd_data, o_pending
    );

    // The arbiter consumes requests and produces grants, the write port and the scoreboard.
    modport slave (
        input  i_r0_valid, i_r0_addr, i_r0_data,
        input  i_r1_valid, i_r1_addr, i_r1_data,
        input  i_issue_valid, i_issue_addr,
        output o_r0_ready, o_r1_ready,
        output o_rd_wren, o_rd_addr, o_rd_data, o_pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 regfile. Requester 0 (single-cycle pipe)
// has fixed priority; requester 1 (multi-cycle unit) is forced through after
// STARVE_LIMIT consecutive refusals. The winning write is registered onto the
// regfile write port, and a scoreboard tracks registers awaiting requester 1.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve;
    logic        r_src;
    logic        r_rdWren;
    logic [4:0]  r_rdAddr;
    logic [31:0] r_rdData;
    logic [31:0] r_pending;

    logic        w_force;
    logic        w_r0Ready;
    logic        w_r1Ready;
    logic        w_transfer;
    logic [4:0]  w_winAddr;
    logic [31:0] w_winData;
    logic [31:0] w_setMask;
    logic [31:0] w_clrMask;

    // Grant decision: requester 0 wins unless requester 1 has hit the starvation limit.
    // Both grants are held low while reset is asserted so nothing is accepted then.
    always_comb begin
        w_force    = bus.i_r1_valid & (r_starve == LIMIT);
        w_r0Ready  = i_reset_n & bus.i_r0_valid & ~w_force;
        w_r1Ready  = i_reset_n & bus.i_r1_valid & (w_force | ~bus.i_r0_valid);
        w_transfer = w_r0Ready | w_r1Ready;
        w_winAddr  = w_r1Ready ? bus.i_r1_addr : bus.i_r0_addr;
        w_winData  = w_r1Ready ? bus.i_r1_data : bus.i_r0_data;
    end

    // Scoreboard edits for this edge: a requester-1 commit on the write port clears
    // its bit, a new issue sets one; the set is OR-ed in last so it wins a collision.
    always_comb begin
        w_clrMask = '0;
        w_setMask = '0;
        if (r_rdWren && r_src) begin
            w_clrMask[r_rdAddr] = 1'b1;
        end
        if (bus.i_issue_valid && (bus.i_issue_addr != 5'd0)) begin
            w_setMask[bus.i_issue_addr] = 1'b1;
        end
    end

    // Count consecutive refusals of requester 1; any accept or idle cycle restarts it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_starve <= 4'd0;
        end else if (w_r1Ready || !bus.i_r1_valid) begin
            r_starve <= 4'd0;
        end else begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Register the winning write; x0 writes are consumed but never enable the regfile,
    // and address/data hold when nothing is accepted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rdWren <= 1'b0;
            r_rdAddr <= 5'd0;
            r_rdData <= 32'd0;
            r_src    <= 1'b0;
        end else if (w_transfer) begin
            r_rdWren <= (w_winAddr != 5'd0);
            r_rdAddr <= w_winAddr;
            r_rdData <= w_winData;
            r_src    <= w_r1Ready;
        end else begin
            r_rdWren <= 1'b0;
        end
    end

    // Pending-destination bits; register 0 can never be pending.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= ((r_pending & ~w_clrMask) | w_setMask) & 32'hFFFF_FFFE;
        end
    end

    assign bus.o_r0_ready = w_r0Ready;
    assign bus.o_r1_ready = w_r1Ready;
    assign bus.o_rd_wren  = r_rdWren;
    assign bus.o_rd_addr  = r_rdAddr;
    assign bus.o_rd_data  = r_rdData;
    assign bus.o_pending  = r_pending;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, hand
// sequences for reset, starvation and scoreboard corners, then a random run
// against a behavioural model of arbitration, regfile contents and pending bits.
module tb_regfile_wb_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic resetN;

    regfile_wb_arbiter_if bus();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk    (clk),
        .i_reset_n(resetN),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0v;
        logic [4:0]  r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1a;
        logic [31:0] r1d;
        logic        expR0;
        logic        expR1;
        logic        expWren;
        logic [4:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[7];

    int totalChecks  = 0;
    int passedChecks = 0;

    // Random-run requester state and reference model state
    logic        r0v, r1v, iv;
    logic [4:0]  r0a, r1a, ia;
    logic [31:0] r0d, r1d;
    logic [31:0] mRegs[32];
    logic [31:0] dRegs[32];
    logic [31:0] mPending;
    logic        mWren, mSrc1;
    logic [4:0]  mAddr;
    logic [31:0] mData;
    int          mWait, obsWait, modelWrites, dutWrites;
    logic        g0, g1, dutR0Acc, dutR1Acc;
    logic [31:0] r1Data;
    logic        forced;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passedChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic ivl, input logic [4:0] ial);
        bus.i_r0_valid    = v0;
        bus.i_r0_addr     = a0;
        bus.i_r0_data     = d0;
        bus.i_r1_valid    = v1;
        bus.i_r1_addr     = a1;
        bus.i_r1_data     = d1;
        bus.i_issue_valid = ivl;
        bus.i_issue_addr  = ial;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd3,  32'h1111_1111, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b1, 5'd3,  32'h1111_1111};
        vecs[1] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd9,  32'h2222_2222, 1'b0, 1'b1, 1'b1, 5'd9,  32'h2222_2222};
        vecs[2] = '{1'b1, 5'd4,  32'h3333_3333, 1'b1, 5'd10, 32'h4444_4444, 1'b1, 1'b0, 1'b1, 5'd4,  32'h3333_3333};
        vecs[3] = '{1'b1, 5'd0,  32'h5555_5555, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b0, 5'd0,  32'h5555_5555};
        vecs[4] = '{1'b0, 5'd0,  32'h0,          1'b0, 5'd0,  32'h0,          1'b0, 1'b0, 1'b0, 5'd0,  32'h5555_5555};
        vecs[5] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd0,  32'h6666_6666, 1'b0, 1'b1, 1'b0, 5'd0,  32'h6666_6666};
        vecs[6] = '{1'b0, 5'd0,  32'h0,          1'b1, 5'd31, 32'h7777_7777, 1'b0, 1'b1, 1'b1, 5'd31, 32'h7777_7777};

        // Reset state, with both requesters asking while reset is held
        resetN = 1'b0;
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0);
        tick();
        tick();
        checkOutput("reset_wren",     32'(bus.o_rd_wren),  32'd0);
        checkOutput("reset_addr",     32'(bus.o_rd_addr),  32'd0);
        checkOutput("reset_data",     bus.o_rd_data,       32'd0);
        checkOutput("reset_pending",  bus.o_pending,       32'd0);
        checkOutput("reset_r0_ready", 32'(bus.o_r0_ready), 32'd0);
        checkOutput("reset_r1_ready", 32'(bus.o_r1_ready), 32'd0);
        idle();
        resetN = 1'b1;
        tick();

        // Sole requester: one-cycle latency onto the write port, then wren drops
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #2;
        checkOutput("sole_r0_ready", 32'(bus.o_r0_ready), 32'd1);
        checkOutput("sole_r1_ready", 32'(bus.o_r1_ready), 32'd0);
        tick();
        idle();
        checkOutput("sole_wren", 32'(bus.o_rd_wren), 32'd1);
        checkOutput("sole_addr", 32'(bus.o_rd_addr), 32'd5);
        checkOutput("sole_data", bus.o_rd_data,      32'hDEAD_BEEF);
        tick();
        checkOutput("sole_wren_drop", 32'(bus.o_rd_wren), 32'd0);
        checkOutput("sole_addr_hold", 32'(bus.o_rd_addr), 32'd5);

        // Table of single transactions, each followed by an idle cycle
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].r0v, vecs[i].r0a, vecs[i].r0d,
                          vecs[i].r1v, vecs[i].r1a, vecs[i].r1d, 1'b0, 5'd0);
            #2;
            checkOutput($sformatf("vec%0d_r0_ready", i), 32'(bus.o_r0_ready), 32'(vecs[i].expR0));
            checkOutput($sformatf("vec%0d_r1_ready", i), 32'(bus.o_r1_ready), 32'(vecs[i].expR1));
            tick();
            idle();
            checkOutput($sformatf("vec%0d_wren", i), 32'(bus.o_rd_wren), 32'(vecs[i].expWren));
            checkOutput($sformatf("vec%0d_addr", i), 32'(bus.o_rd_addr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d_data", i), bus.o_rd_data,      vecs[i].expData);
            tick();
        end

        // Continuous contention: four r0 accepts then one forced r1 accept, repeating
        r1Data = 32'hA000_0000;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 5'd1, 32'hB000_0000 + 32'(k), 1'b1, 5'd2, r1Data, 1'b0, 5'd0);
            #2;
            forced = ((k % 5) == 4);
            checkOutput("contend_r0_ready", 32'(bus.o_r0_ready), 32'(!forced));
            checkOutput("contend_r1_ready", 32'(bus.o_r1_ready), 32'(forced));
            tick();
            checkOutput("contend_addr", 32'(bus.o_rd_addr), forced ? 32'd2 : 32'd1);
            checkOutput("contend_data", bus.o_rd_data, forced ? r1Data : 32'hB000_0000 + 32'(k));
            if (forced) r1Data = r1Data + 32'd1;
        end
        idle();
        tick();

        // Scoreboard: issue 7, requester-1 commit with a re-issue on the clearing edge
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        tick();
        idle();
        checkOutput("sb_issue_set", bus.o_pending, 32'h0000_0080);
        tick();
        checkOutput("sb_issue_hold", bus.o_pending, 32'h0000_0080);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE_0007, 1'b0, 5'd0);
        #2;
        checkOutput("sb_r1_ready", 32'(bus.o_r1_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        checkOutput("sb_still_pending", bus.o_pending, 32'h0000_0080);
        checkOutput("sb_commit_wren", 32'(bus.o_rd_wren), 32'd1);
        tick();
        idle();
        checkOutput("sb_reissue_wins", bus.o_pending, 32'h0000_0080);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE_0017, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("sb_pending_cycle_n", bus.o_pending, 32'h0000_0080);
        tick();
        checkOutput("sb_cleared", bus.o_pending, 32'd0);

        // x0 handling and requester-0 commits leaving the scoreboard alone
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        tick();
        idle();
        checkOutput("x0_setup_pending", bus.o_pending, 32'h0000_1000);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0);
        #2;
        checkOutput("x0_r1_ready", 32'(bus.o_r1_ready), 32'd1);
        tick();
        idle();
        checkOutput("x0_wren", 32'(bus.o_rd_wren), 32'd0);
        checkOutput("x0_data", bus.o_rd_data, 32'h1234_5678);
        tick();
        checkOutput("x0_pending_kept", bus.o_pending, 32'h0000_1000);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        tick();
        idle();
        checkOutput("x0_issue_ignored", bus.o_pending, 32'h0000_1000);
        applyStimulus(1'b1, 5'd12, 32'h0BAD_F00D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        tick();
        idle();
        checkOutput("r0_commit_wren", 32'(bus.o_rd_wren), 32'd1);
        tick();
        checkOutput("r0_commit_no_clear", bus.o_pending, 32'h0000_1000);

        // Reset dropped mid-write with both requesters valid
        applyStimulus(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd10, 32'h0000_00AA, 1'b0, 5'd0);
        tick();
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midreset_wren",     32'(bus.o_rd_wren),  32'd0);
        checkOutput("midreset_addr",     32'(bus.o_rd_addr),  32'd0);
        checkOutput("midreset_data",     bus.o_rd_data,       32'd0);
        checkOutput("midreset_pending",  bus.o_pending,       32'd0);
        checkOutput("midreset_r0_ready", 32'(bus.o_r0_ready), 32'd0);
        checkOutput("midreset_r1_ready", 32'(bus.o_r1_ready), 32'd0);
        tick();
        resetN = 1'b1;
        #2;
        checkOutput("postreset_r0_ready", 32'(bus.o_r0_ready), 32'd1);
        checkOutput("postreset_r1_ready", 32'(bus.o_r1_ready), 32'd0);
        tick();
        checkOutput("postreset_addr", 32'(bus.o_rd_addr), 32'd9);
        checkOutput("postreset_data", bus.o_rd_data,      32'h0000_0099);
        idle();
        tick();

        // Clean start for the random run
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        for (int r = 0; r < 32; r++) begin
            mRegs[r] = 32'd0;
            dRegs[r] = 32'd0;
        end
        mPending = 32'd0;
        mWren = 1'b0; mSrc1 = 1'b0; mAddr = 5'd0; mData = 32'd0;
        mWait = 0; obsWait = 0; modelWrites = 0; dutWrites = 0;
        r0v = 1'b0; r1v = 1'b0; r0a = 5'd0; r1a = 5'd0; r0d = 32'd0; r1d = 32'd0;

        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!r0v) begin
                r0v = ($urandom_range(0, 99) < 70);
                r0a = 5'($urandom_range(0, 31));
                r0d = $urandom;
            end
            if (!r1v) begin
                r1v = ($urandom_range(0, 99) < 55);
                r1a = 5'($urandom_range(0, 31));
                r1d = $urandom;
            end
            iv = ($urandom_range(0, 3) == 0);
            ia = 5'($urandom_range(0, 31));
            applyStimulus(r0v, r0a, r0d, r1v, r1a, r1d, iv, ia);
            #2;

            // Reference: requester 1 wins if alone, or once it has been refused LIMIT times
            g1 = r1v && (!r0v || (mWait >= LIMIT));
            g0 = r0v && !g1;
            checkOutput("rand_r0_ready", 32'(bus.o_r0_ready), 32'(g0));
            checkOutput("rand_r1_ready", 32'(bus.o_r1_ready), 32'(g1));

            if (bus.o_rd_wren) dRegs[bus.o_rd_addr] = bus.o_rd_data;
            if (mWren) mRegs[mAddr] = mData;

            dutR0Acc = r0v && bus.o_r0_ready;
            dutR1Acc = r1v && bus.o_r1_ready;
            if (dutR0Acc || dutR1Acc) dutWrites++;
            if (dutR1Acc) begin
                checkOutput("r1_wait_bound", 32'(obsWait <= LIMIT), 32'd1);
            end
            if (r1v && !bus.o_r1_ready) obsWait++;
            else obsWait = 0;

            tick();

            if (mWren && mSrc1) mPending[mAddr] = 1'b0;
            if (iv && (ia != 5'd0)) mPending[ia] = 1'b1;
            if (g0 || g1) begin
                mAddr = g1 ? r1a : r0a;
                mData = g1 ? r1d : r0d;
                mWren = (mAddr != 5'd0);
                mSrc1 = g1;
                modelWrites++;
            end else begin
                mWren = 1'b0;
            end
            mWait = (r1v && !g1) ? mWait + 1 : 0;

            checkOutput("rand_wren",    32'(bus.o_rd_wren), 32'(mWren));
            checkOutput("rand_addr",    32'(bus.o_rd_addr), 32'(mAddr));
            checkOutput("rand_data",    bus.o_rd_data,      mData);
            checkOutput("rand_pending", bus.o_pending,      mPending);

            if (dutR0Acc) r0v = 1'b0;
            if (dutR1Acc) r1v = 1'b0;
        end

        // Let the last registered write land, then compare whole regfiles
        idle();
        #2;
        if (bus.o_rd_wren) dRegs[bus.o_rd_addr] = bus.o_rd_data;
        if (mWren) mRegs[mAddr] = mData;
        checkOutput("write_count", 32'(dutWrites), 32'(modelWrites));
        for (int r = 0; r < 32; r++) begin
            checkOutput($sformatf("regfile_x%0d", r), dRegs[r], mRegs[r]);
        end
        tick();

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-destination scoreboard for the 32x32 register file. It shares the regfile's single write port between two writeback sources: requester 0 is the single-cycle pipeline writeback and requester 1 is a multi-cycle unit such as a divider or load unit. It registers the winning write onto the regfile's `i_rd_wren/i_rd_addr/i_rd_data` inputs. It also tracks which registers are awaiting a requester-1 result, so the issue logic can stall on RAW hazards.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles requester 1 may be refused before it is forced through. Legal range is 1..15.
- `i_clk` in, 1: clock, rising edge.
- `i_reset_n` in, 1: asynchronous, active-low reset.
- `i_r0_valid` in, 1: requester 0 has a write.
- `i_r0_addr` in, 5: requester 0 destination.
- `i_r0_data` in, 32: requester 0 data.
- `o_r0_ready` out, 1: requester 0 write accepted this cycle.
- `i_r1_valid` in, 1: requester 1 has a write.
- `i_r1_addr` in, 5: requester 1 destination.
- `i_r1_data` in, 32: requester 1 data.
- `o_r1_ready` out, 1: requester 1 write accepted this cycle.
- `i_issue_valid` in, 1: an instruction routed to requester 1 is issued this cycle.
- `i_issue_addr` in, 5: destination of that instruction.
- `o_rd_wren` out, 1: regfile write enable (registered).
- `o_rd_addr` out, 5: regfile write address (registered).
- `o_rd_data` out, 32: regfile write data (registered).
- `o_pending` out, 32: bit k=1 means register k awaits a requester-1 result. Bit 0 is always 0.

## Operation
**Handshake**
- A transfer occurs on a rising edge when `valid` and `ready` are both high.
- `ready` is combinational from the valids and the starvation counter. At most one ready is high per cycle.
- A requester holds `valid`, `addr` and `data` stable until it is accepted.

**Arbitration**
- Requester 0 has fixed priority.
- Starvation counter `starve` (4 bits):
  - increments when `i_r1_valid` is high and `o_r1_ready` is low;
  - clears when requester 1 is accepted or `i_r1_valid` is low.
- When `starve == STARVE_LIMIT` and `i_r1_valid` is high, requester 1 is granted and `o_r0_ready` is 0 that cycle.
- `o_r0_ready = i_r0_valid & ~force`.
- `o_r1_ready = i_r1_valid & (force | ~i_r0_valid)`.

**Write register**
- On an accepted transfer, `o_rd_addr` and `o_rd_data` load from the winner.
- `o_rd_wren` loads 1 only if the winner's address is nonzero. A write to x0 is consumed but suppressed.
- With no transfer, `o_rd_wren` loads 0 and `o_rd_addr`/`o_rd_data` hold their values.
- An internal `src` flag records which requester won.

**Scoreboard**
- Set: on `i_issue_valid` with `i_issue_addr != 0`, bit `i_issue_addr` sets.
- Clear: on an edge where `o_rd_wren` is high and `src` is requester 1, bit `o_rd_addr` clears. This is the same edge the regfile stores the data.
- A set and a clear of the same bit on the same edge: set wins, because it is a new outstanding result.
- Issuing to an already-pending register leaves the bit at 1. The issue logic guarantees one outstanding result per register.
- Requester-0 commits never touch `o_pending`.

## Timing
- Reset (`i_reset_n` low, asynchronous) forces:
  - `o_rd_wren`, `o_rd_addr`, `o_rd_data` to 0;
  - `o_pending` to 0;
  - `starve` and `src` to 0.
- While in reset, `o_r0_ready` and `o_r1_ready` are 0. A transfer in flight is dropped.
- Latency: accepted at edge N, `o_rd_*` valid during cycle N..N+1, regfile updated at edge N+1.
- The `o_pending` bit for a requester-1 write falls at edge N+1. A regfile read in the cycle after the bit falls returns the new value.
- Back-to-back accepts give one write per cycle with no bubbles.
- Forced grant: requester 1 is refused for `STARVE_LIMIT` consecutive cycles and accepted on the next. Its worst-case wait is `STARVE_LIMIT` cycles.
- Reset deasserted mid-stream: the arbiter resumes with `starve = 0` and priority to requester 0.

## Test plan
- Reset: assert `i_reset_n` low mid-write with both valids high. Outputs go to 0 immediately and both readies are 0. After release, the first accept goes to requester 0.
- Sole requester: `i_r0_valid` only, addr 5, data 0xDEADBEEF, accepted at edge N. At edge N+1: `o_rd_wren=1`, `o_rd_addr=5`, `o_rd_data=0xDEADBEEF`. At edge N+2: `o_rd_wren=0`.
- Contention with `STARVE_LIMIT=4`: both valids high continuously.
  - Requester 0 is accepted 4 times, then requester 1 once, repeating.
  - `starve` runs 0,1,2,3,4,0.
  - `o_r0_ready` is 0 exactly on the forced cycles.
- Scoreboard:
  - Issue addr 7: bit 7 is 1 from the next edge.
  - Requester-1 write to 7 accepted at edge N: bit 7 is still 1 in cycle N, 0 after edge N+1.
  - A re-issue of 7 at edge N+1 keeps bit 7 at 1.
- x0 writes:
  - Requester 1 writes addr 0: accepted, `o_rd_wren` stays 0, `o_pending` unchanged.
  - Issue of addr 0: `o_pending[0]` stays 0.
- Randomised-valid run of 1000 cycles against a reference model:
  - no lost or duplicated writes;
  - requester-1 wait never exceeds `STARVE_LIMIT`;
  - regfile contents match the model.
